// File: rtl/lc3_mem_access_unit_if.sv
// Bus bundle between the LC3 control/datapath (master) and the MAR/MDR memory access unit (slave).
interface lc3_mem_access_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  MAR_LE;
  logic                  MAR_SEL;
  logic [ADDR_WIDTH-1:0] EA;
  logic [DATA_WIDTH-1:0] BUS_IN;
  logic                  MDR_LE;
  logic                  MEM_EN;
  logic                  MEM_WE;
  logic [ADDR_WIDTH-1:0] MAR;
  logic [DATA_WIDTH-1:0] MDR;
  logic                  BUSY;
  logic                  R;
  logic                  ADDR_ERR;

  modport master (
    output MAR_LE, MAR_SEL, EA, BUS_IN, MDR_LE, MEM_EN, MEM_WE,
    input  MAR, MDR, BUSY, R, ADDR_ERR
  );

  modport slave (
    input  MAR_LE, MAR_SEL, EA, BUS_IN, MDR_LE, MEM_EN, MEM_WE,
    output MAR, MDR, BUSY, R, ADDR_ERR
  );
endinterface

// File: rtl/lc3_mem_access_unit.sv
// LC3 MAR/MDR memory access unit: MAR source mux, MAR/MDR registers, internal synchronous
// RAM and a wait-state FSM that reports completion with a one-cycle ready pulse.
module lc3_mem_access_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  lc3_mem_access_unit_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  state_t                  r_state, w_state_next;
  logic [3:0]              r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0]   r_mar;
  logic [DATA_WIDTH-1:0]   r_mdr;
  logic                    r_we;
  logic                    r_err;
  logic                    r_ready;
  logic                    r_addr_err;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [DATA_WIDTH-1:0]   r_mem [0:(1<<DEPTH_LOG2)-1];

  logic [ADDR_WIDTH-1:0]   w_bus_addr;
  logic [ADDR_WIDTH-1:0]   w_mar_mux;
  logic [ADDR_WIDTH-1:0]   w_mar_accept;
  logic                    w_range_err;
  logic                    w_accept;
  logic                    w_mem_we;
  logic [DEPTH_LOG2-1:0]   w_idx;

  // Indirect MAR source takes the low address bits of the bus, zero-extended if narrower.
  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_bus_trunc
      assign w_bus_addr = bus.BUS_IN[ADDR_WIDTH-1:0];
    end else begin : g_bus_zext
      assign w_bus_addr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, bus.BUS_IN};
    end
  endgenerate

  assign w_mar_mux    = bus.MAR_SEL ? w_bus_addr : bus.EA;
  // A request issued together with MAR_LE is checked against the address being loaded.
  assign w_mar_accept = bus.MAR_LE ? w_mar_mux : r_mar;
  assign w_range_err  = |(w_mar_accept >> DEPTH_LOG2);
  assign w_accept     = (r_state == S_IDLE) && bus.MEM_EN;
  assign w_idx        = r_mar[DEPTH_LOG2-1:0];
  assign w_mem_we     = (r_state == S_XFER) && r_we && !r_err;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.MEM_EN) begin
          // Out-of-range requests pass through XFER without touching RAM.
          w_state_next = w_range_err ? S_XFER : S_WAIT;
          w_cnt_next   = LP_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_XFER;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_XFER:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mar      <= '0;
      r_mdr      <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_ready    <= (r_state == S_XFER);
      r_addr_err <= (r_state == S_XFER) && r_err;
      if (r_state == S_IDLE) begin
        if (bus.MAR_LE) r_mar <= w_mar_mux;
        if (bus.MDR_LE) r_mdr <= bus.BUS_IN;
        if (w_accept) begin
          r_we  <= bus.MEM_WE;
          r_err <= w_range_err;
        end
      end else if ((r_state == S_XFER) && !r_we && !r_err) begin
        r_mdr <= r_rd_data;
      end
    end
  end

  // MAR is frozen from acceptance, so the registered read is valid by the time XFER is reached.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= r_mdr;
    r_rd_data <= r_mem[w_idx];
  end

  assign bus.MAR      = r_mar;
  assign bus.MDR      = r_mdr;
  assign bus.BUSY     = (r_state != S_IDLE);
  assign bus.R        = r_ready;
  assign bus.ADDR_ERR = r_addr_err;
endmodule

// File: tb/tb_lc3_mem_access_unit.sv
// Directed bench for lc3_mem_access_unit: reset, write/read, indirect MAR, range error,
// ignored requests while busy and reset in the middle of a write.
module tb_lc3_mem_access_unit;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DL = 10;
  localparam int WS = 2;
  localparam int LAT_OK  = WS + 2;
  localparam int LAT_ERR = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  lc3_mem_access_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  lc3_mem_access_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.MAR_LE  = 1'b0;
    bus.MAR_SEL = 1'b0;
    bus.EA      = '0;
    bus.BUS_IN  = '0;
    bus.MDR_LE  = 1'b0;
    bus.MEM_EN  = 1'b0;
    bus.MEM_WE  = 1'b0;
  endtask

  task automatic load_mar(input logic [AW-1:0] a);
    bus.MAR_SEL = 1'b0;
    bus.EA      = a;
    bus.MAR_LE  = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic load_mdr(input logic [DW-1:0] d);
    bus.BUS_IN = d;
    bus.MDR_LE = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic start(input logic we);
    bus.MEM_EN = 1'b1;
    bus.MEM_WE = we;
    tick();
    clear_in();
  endtask

  // Called just after the accepting edge (plus 'elapsed' further edges); R must
  // appear exactly 'exp_lat' edges after acceptance and last a single cycle.
  task automatic wait_r(input string tag, input int exp_lat, input int elapsed,
                        input logic exp_err, input logic [DW-1:0] exp_mdr);
    int k;
    k = elapsed;
    check_eq({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
    while (bus.R !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check_eq({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check_eq({tag, "_aerr"}, 32'(bus.ADDR_ERR), 32'(exp_err));
    check_eq({tag, "_mdr"}, 32'(bus.MDR), 32'(exp_mdr));
    $display("access %s: R after %0d cycles, MAR=0x%04h MDR=0x%04h ADDR_ERR=%0b",
             tag, k, bus.MAR, bus.MDR, bus.ADDR_ERR);
    tick();
    check_eq({tag, "_rpulse"}, 32'(bus.R), 32'd0);
    check_eq({tag, "_idle"}, 32'(bus.BUSY), 32'd0);
  endtask

  task automatic write_word(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_mar(a);
    load_mdr(d);
    start(1'b1);
    wait_r(tag, LAT_OK, 0, 1'b0, d);
  endtask

  task automatic read_word(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    load_mar(a);
    load_mdr(16'h0000);
    start(1'b0);
    wait_r(tag, LAT_OK, 0, 1'b0, exp);
  endtask

  initial begin
    clear_in();
    tick();
    tick();
    check_eq("rst_mar", 32'(bus.MAR), 32'h0);
    check_eq("rst_busy", 32'(bus.BUSY), 32'h0);
    rst = 1'b0;
    tick();

    // 1: asynchronous reset while idle with non-zero registers
    load_mar(16'h0123);
    load_mdr(16'hABCD);
    check_eq("pre_rst_mdr", 32'(bus.MDR), 32'hABCD);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_mar", 32'(bus.MAR), 32'h0);
    check_eq("arst_mdr", 32'(bus.MDR), 32'h0);
    check_eq("arst_busy", 32'(bus.BUSY), 32'h0);
    check_eq("arst_r", 32'(bus.R), 32'h0);
    check_eq("arst_aerr", 32'(bus.ADDR_ERR), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // 2: write 0xBEEF to 0x0010 with loads in the accepting cycle, then read it back
    bus.EA = 16'h0010; bus.MAR_SEL = 1'b0; bus.MAR_LE = 1'b1;
    bus.BUS_IN = 16'hBEEF; bus.MDR_LE = 1'b1;
    bus.MEM_EN = 1'b1; bus.MEM_WE = 1'b1;
    tick();
    clear_in();
    check_eq("t2_mar", 32'(bus.MAR), 32'h0010);
    check_eq("t2_r0", 32'(bus.R), 32'h0);
    wait_r("t2_wr", LAT_OK, 0, 1'b0, 16'hBEEF);
    load_mdr(16'h0000);
    check_eq("t2_mdr_clr", 32'(bus.MDR), 32'h0);
    start(1'b0);
    wait_r("t2_rd", LAT_OK, 0, 1'b0, 16'hBEEF);

    // 3: indirect MAR load from the bus in the same cycle as the read request
    load_mar(16'h0055);
    load_mdr(16'h0000);
    bus.MAR_SEL = 1'b1; bus.BUS_IN = 16'h0010; bus.MAR_LE = 1'b1;
    bus.MEM_EN = 1'b1; bus.MEM_WE = 1'b0;
    tick();
    clear_in();
    check_eq("t3_mar", 32'(bus.MAR), 32'h0010);
    wait_r("t3_rd", LAT_OK, 0, 1'b0, 16'hBEEF);

    // Boundary addresses: last and first RAM words
    write_word("b_wr_top", 16'h03FF, 16'h0F0F);
    write_word("b_wr_0", 16'h0000, 16'h7777);
    read_word("b_rd_top", 16'h03FF, 16'h0F0F);

    // 4: out-of-range write must flag ADDR_ERR and leave mem[0] and MDR alone
    load_mdr(16'hAAAA);
    load_mar(16'h0400);
    start(1'b1);
    wait_r("t4_err", LAT_ERR, 0, 1'b1, 16'hAAAA);
    read_word("t4_rd0", 16'h0000, 16'h7777);

    // 5: requests during WAIT are ignored
    load_mar(16'h0010);
    load_mdr(16'h1111);
    start(1'b1);
    bus.MAR_SEL = 1'b0; bus.EA = 16'h0020; bus.MAR_LE = 1'b1;
    bus.BUS_IN = 16'h5555; bus.MDR_LE = 1'b1;
    bus.MEM_EN = 1'b1; bus.MEM_WE = 1'b0;
    tick();
    clear_in();
    check_eq("t5_mar", 32'(bus.MAR), 32'h0010);
    check_eq("t5_mdr", 32'(bus.MDR), 32'h1111);
    wait_r("t5_wr", LAT_OK, 1, 1'b0, 16'h1111);
    tick();
    check_eq("t5_no_2nd_busy", 32'(bus.BUSY), 32'h0);
    check_eq("t5_no_2nd_r", 32'(bus.R), 32'h0);
    read_word("t5_rd", 16'h0010, 16'h1111);

    // 6: reset during WAIT of a write cancels it
    write_word("t6_init", 16'h0030, 16'h1234);
    load_mar(16'h0030);
    load_mdr(16'h9999);
    start(1'b1);
    tick();
    check_eq("t6_busy_wait", 32'(bus.BUSY), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_busy", 32'(bus.BUSY), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t6_no_r", 32'(bus.R), 32'h0);
    end
    read_word("t6_rd", 16'h0030, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
